// File: rtl/cdb_if.sv
// Producer-side and broadcast signals of the common data bus arbiter.
// master drives the three producer inputs; slave is the arbiter.
interface cdb_if #(
  parameter int unsigned ROBWD = 4
);
  logic             ex_in_flag;
  logic [ROBWD-1:0] ex_in_rob_id;
  logic [31:0]      ex_in_val;
  logic [31:0]      ex_in_rel_pc;
  logic             ex_full;

  logic             ld_in_flag;
  logic [ROBWD-1:0] ld_in_rob_id;
  logic [31:0]      ld_in_val;
  logic             ld_full;

  logic             st_in_flag;
  logic [ROBWD-1:0] st_in_rob_id;
  logic             st_full;

  logic             cdb_flag;
  logic [1:0]       cdb_src;
  logic [ROBWD-1:0] cdb_rob_id;
  logic [31:0]      cdb_val;
  logic [31:0]      cdb_rel_pc;
  logic             ovf_err;

  modport master (
    output ex_in_flag, ex_in_rob_id, ex_in_val, ex_in_rel_pc,
    output ld_in_flag, ld_in_rob_id, ld_in_val,
    output st_in_flag, st_in_rob_id,
    input  ex_full, ld_full, st_full,
    input  cdb_flag, cdb_src, cdb_rob_id, cdb_val, cdb_rel_pc, ovf_err
  );

  modport slave (
    input  ex_in_flag, ex_in_rob_id, ex_in_val, ex_in_rel_pc,
    input  ld_in_flag, ld_in_rob_id, ld_in_val,
    input  st_in_flag, st_in_rob_id,
    output ex_full, ld_full, st_full,
    output cdb_flag, cdb_src, cdb_rob_id, cdb_val, cdb_rel_pc, ovf_err
  );
endinterface

// File: rtl/cdb_arbiter.sv
// Round-robin arbiter sharing one registered CDB among ex, ld and st producers.
// Each producer has a small FIFO; an empty FIFO lets its same-cycle input bypass.
module cdb_arbiter #(
  parameter int unsigned ROBWD = 4,
  parameter int unsigned DEPTH = 4
) (
  input  logic    clk,
  input  logic    rst,
  input  logic    rdy,
  input  logic    flush,
  cdb_if.slave    bus
);

  localparam int unsigned PW   = $clog2(DEPTH);
  localparam int unsigned CW   = PW + 1;
  localparam int unsigned NSRC = 3;

  typedef enum logic [1:0] {
    SRC_EX = 2'd0,
    SRC_LD = 2'd1,
    SRC_ST = 2'd2
  } src_e;

  typedef struct packed {
    logic [ROBWD-1:0] rob_id;
    logic [31:0]      val;
    logic [31:0]      rel_pc;
  } entry_t;

  entry_t          mem    [NSRC][DEPTH];
  logic [PW-1:0]   rd_ptr [NSRC];
  logic [PW-1:0]   wr_ptr [NSRC];
  logic [CW-1:0]   cnt    [NSRC];

  src_e            rr_q, rr_d;
  logic            flag_q;
  src_e            src_q;
  entry_t          data_q;
  logic            ovf_q;

  entry_t          in_e   [NSRC];
  entry_t          cand   [NSRC];
  src_e            ord    [NSRC];
  logic [NSRC-1:0] in_v, cand_v, grant, pop, push, push_ok, ovf_hit;
  logic            win_any;
  src_e            win_src;

  // Normalise producer inputs into common entries (absent fields are zero)
  always_comb begin
    in_v    = {bus.st_in_flag, bus.ld_in_flag, bus.ex_in_flag};
    in_e[0] = '{rob_id: bus.ex_in_rob_id, val: bus.ex_in_val, rel_pc: bus.ex_in_rel_pc};
    in_e[1] = '{rob_id: bus.ld_in_rob_id, val: bus.ld_in_val, rel_pc: 32'd0};
    in_e[2] = '{rob_id: bus.st_in_rob_id, val: 32'd0,         rel_pc: 32'd0};
  end

  // FIFO head competes when present, otherwise the bypassing input
  always_comb begin
    for (int unsigned s = 0; s < NSRC; s++) begin
      cand_v[s] = (cnt[s] != '0) || in_v[s];
      cand[s]   = (cnt[s] != '0) ? mem[s][rd_ptr[s]] : in_e[s];
    end
  end

  // Round-robin search starting after the last winner, plus push/pop decisions
  always_comb begin
    ord     = '{SRC_EX, SRC_LD, SRC_ST};
    win_any = 1'b0;
    win_src = rr_q;
    rr_d    = rr_q;
    grant   = '0;
    pop     = '0;
    push    = '0;
    push_ok = '0;
    ovf_hit = '0;

    case (rr_q)
      SRC_EX:  ord = '{SRC_LD, SRC_ST, SRC_EX};
      SRC_LD:  ord = '{SRC_ST, SRC_EX, SRC_LD};
      default: ord = '{SRC_EX, SRC_LD, SRC_ST};
    endcase

    for (int unsigned k = 0; k < NSRC; k++) begin
      if (!win_any && cand_v[ord[k]]) begin
        win_any = 1'b1;
        win_src = ord[k];
      end
    end
    if (win_any) rr_d = win_src;

    for (int unsigned s = 0; s < NSRC; s++) begin
      grant[s]   = win_any && (win_src == src_e'(2'(s)));
      pop[s]     = grant[s] && (cnt[s] != '0);
      push[s]    = in_v[s] && !(grant[s] && (cnt[s] == '0));
      // A full FIFO still takes a push when its head leaves on the same edge
      push_ok[s] = push[s] && ((cnt[s] != CW'(DEPTH)) || pop[s]);
      ovf_hit[s] = push[s] && !push_ok[s];
    end
  end

  // Control state: pointers, counts, RR pointer and the registered CDB
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned s = 0; s < NSRC; s++) begin
        rd_ptr[s] <= '0;
        wr_ptr[s] <= '0;
        cnt[s]    <= '0;
      end
      rr_q   <= SRC_ST;
      flag_q <= 1'b0;
      src_q  <= SRC_EX;
      data_q <= '0;
      ovf_q  <= 1'b0;
    end else if (rdy) begin
      if (flush) begin
        for (int unsigned s = 0; s < NSRC; s++) begin
          rd_ptr[s] <= '0;
          wr_ptr[s] <= '0;
          cnt[s]    <= '0;
        end
        flag_q <= 1'b0;
      end else begin
        for (int unsigned s = 0; s < NSRC; s++) begin
          if (pop[s])     rd_ptr[s] <= rd_ptr[s] + PW'(1);
          if (push_ok[s]) wr_ptr[s] <= wr_ptr[s] + PW'(1);
          cnt[s] <= cnt[s] + CW'(push_ok[s]) - CW'(pop[s]);
        end
        if (|ovf_hit) ovf_q <= 1'b1;
        rr_q   <= rr_d;
        flag_q <= win_any;
        if (win_any) begin
          src_q  <= win_src;
          data_q <= cand[win_src];
        end
      end
    end
  end

  // FIFO storage; no reset needed since counts gate every read
  always_ff @(posedge clk) begin
    if (!rst && rdy && !flush) begin
      for (int unsigned s = 0; s < NSRC; s++) begin
        if (push_ok[s]) mem[s][wr_ptr[s]] <= in_e[s];
      end
    end
  end

  assign bus.cdb_flag   = flag_q;
  assign bus.cdb_src    = src_q;
  assign bus.cdb_rob_id = data_q.rob_id;
  assign bus.cdb_val    = data_q.val;
  assign bus.cdb_rel_pc = data_q.rel_pc;
  assign bus.ovf_err    = ovf_q;
  assign bus.ex_full    = (cnt[0] == CW'(DEPTH));
  assign bus.ld_full    = (cnt[1] == CW'(DEPTH));
  assign bus.st_full    = (cnt[2] == CW'(DEPTH));

endmodule
